// File: rtl/gpr_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_sched
// Brief    : GPR write-back scheduler (3-way round-robin onto one registered
//            write port) plus busy-bit scoreboard that drives issue hazards.
//            Optional macro GPR_WB_SCHED_BYPASS_EN masks operands that are
//            committing this cycle.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_wb_sched #(
    parameter int GPR_ADDR_W = 5,
    parameter int XLEN       = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  alu_wb_valid_i,
    input  logic [GPR_ADDR_W-1:0] alu_wb_addr_i,
    input  logic [XLEN-1:0]       alu_wb_data_i,
    output logic                  alu_wb_ready_o,
    input  logic                  lsu_wb_valid_i,
    input  logic [GPR_ADDR_W-1:0] lsu_wb_addr_i,
    input  logic [XLEN-1:0]       lsu_wb_data_i,
    output logic                  lsu_wb_ready_o,
    input  logic                  mdu_wb_valid_i,
    input  logic [GPR_ADDR_W-1:0] mdu_wb_addr_i,
    input  logic [XLEN-1:0]       mdu_wb_data_i,
    output logic                  mdu_wb_ready_o,
    input  logic                  sb_set_i,
    input  logic [GPR_ADDR_W-1:0] sb_set_addr_i,
    input  logic [GPR_ADDR_W-1:0] rs1_addr_i,
    input  logic [GPR_ADDR_W-1:0] rs2_addr_i,
    input  logic [GPR_ADDR_W-1:0] rd_addr_i,
    output logic                  hazard_o,
    output logic                  gpr_wr_en_o,
    output logic [GPR_ADDR_W-1:0] gpr_wr_addr_o,
    output logic [XLEN-1:0]       gpr_wr_data_o
);

    localparam int         c_NUM_REGS = 1 << GPR_ADDR_W;
    localparam logic [1:0] c_SRC_ALU  = 2'd0;
    localparam logic [1:0] c_SRC_LSU  = 2'd1;
    localparam logic [1:0] c_SRC_MDU  = 2'd2;

    logic [1:0]            r_ptr;
    logic [1:0]            w_next_ptr;
    logic [2:0]            w_req;
    logic [2:0]            w_gnt;
    logic [GPR_ADDR_W-1:0] w_gnt_addr;
    logic [XLEN-1:0]       w_gnt_data;

    logic                  r_wr_en;
    logic [GPR_ADDR_W-1:0] r_wr_addr;
    logic [XLEN-1:0]       r_wr_data;

    logic [c_NUM_REGS-1:0] r_busy;
    logic [c_NUM_REGS-1:0] w_set_vec;
    logic [c_NUM_REGS-1:0] w_clr_vec;
    logic [c_NUM_REGS-1:0] w_busy_next;

    logic                  w_haz_rs1;
    logic                  w_haz_rs2;
    logic                  w_haz_rd;

    assign w_req = {mdu_wb_valid_i, lsu_wb_valid_i, alu_wb_valid_i};

    // Priority rotates starting at the pointer: ALU -> LSU -> MDU -> ALU.
    always_comb begin
        w_gnt = 3'b000;
        case (r_ptr)
            c_SRC_LSU: begin
                if (w_req[1])      w_gnt = 3'b010;
                else if (w_req[2]) w_gnt = 3'b100;
                else if (w_req[0]) w_gnt = 3'b001;
            end
            c_SRC_MDU: begin
                if (w_req[2])      w_gnt = 3'b100;
                else if (w_req[0]) w_gnt = 3'b001;
                else if (w_req[1]) w_gnt = 3'b010;
            end
            default: begin
                if (w_req[0])      w_gnt = 3'b001;
                else if (w_req[1]) w_gnt = 3'b010;
                else if (w_req[2]) w_gnt = 3'b100;
            end
        endcase
    end

    always_comb begin
        w_next_ptr = r_ptr;
        w_gnt_addr = alu_wb_addr_i;
        w_gnt_data = alu_wb_data_i;
        if (w_gnt[0]) begin
            w_next_ptr = c_SRC_LSU;
        end else if (w_gnt[1]) begin
            w_next_ptr = c_SRC_MDU;
            w_gnt_addr = lsu_wb_addr_i;
            w_gnt_data = lsu_wb_data_i;
        end else if (w_gnt[2]) begin
            w_next_ptr = c_SRC_ALU;
            w_gnt_addr = mdu_wb_addr_i;
            w_gnt_data = mdu_wb_data_i;
        end
    end

    assign alu_wb_ready_o = w_gnt[0] & ~rst_i;
    assign lsu_wb_ready_o = w_gnt[1] & ~rst_i;
    assign mdu_wb_ready_o = w_gnt[2] & ~rst_i;

    // x0 grants still load addr/data, but never raise the write enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr     <= c_SRC_ALU;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_ptr   <= w_next_ptr;
            r_wr_en <= (|w_gnt) && (w_gnt_addr != '0);
            if (|w_gnt) begin
                r_wr_addr <= w_gnt_addr;
                r_wr_data <= w_gnt_data;
            end
        end
    end

    // Set is applied after clear so a same-cycle re-issue keeps the bit.
    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        if (sb_set_i)
            w_set_vec[sb_set_addr_i] = 1'b1;
        if (r_wr_en)
            w_clr_vec[r_wr_addr] = 1'b1;
        w_busy_next    = (r_busy & ~w_clr_vec) | w_set_vec;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_busy <= '0;
        else
            r_busy <= w_busy_next;
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i && sb_set_i && (sb_set_addr_i != '0)) begin
            assert (!r_busy[sb_set_addr_i] || w_clr_vec[sb_set_addr_i])
                else $error("gpr_wb_sched: scoreboard set of busy register x%0d", sb_set_addr_i);
        end
    end
`endif

`ifdef GPR_WB_SCHED_BYPASS_EN
    assign w_haz_rs1 = r_busy[rs1_addr_i] & ~(r_wr_en && (r_wr_addr == rs1_addr_i));
    assign w_haz_rs2 = r_busy[rs2_addr_i] & ~(r_wr_en && (r_wr_addr == rs2_addr_i));
    assign w_haz_rd  = r_busy[rd_addr_i]  & ~(r_wr_en && (r_wr_addr == rd_addr_i));
`else
    assign w_haz_rs1 = r_busy[rs1_addr_i];
    assign w_haz_rs2 = r_busy[rs2_addr_i];
    assign w_haz_rd  = r_busy[rd_addr_i];
`endif

    assign hazard_o      = w_haz_rs1 | w_haz_rs2 | w_haz_rd;
    assign gpr_wr_en_o   = r_wr_en;
    assign gpr_wr_addr_o = r_wr_addr;
    assign gpr_wr_data_o = r_wr_data;

endmodule
`default_nettype wire
